// File: rtl/next_pc_mux_pkg.sv
// next_pc_mux_pkg: core-wide PC width, reset vector and next-PC source encoding
package next_pc_mux_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_RSVD   = 2'b11
  } pc_src_e;
endpackage

// File: rtl/next_pc_mux_pc_reg.sv
// next_pc_mux_pc_reg: architectural PC register with sync reset and stall
module next_pc_mux_pc_reg #(
  parameter int XLEN = next_pc_mux_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = next_pc_mux_pkg::RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);
  logic [XLEN-1:0] pc_d, pc_q;
  always_comb pc_d = stall ? pc_q : d;
  always_ff @(posedge clk)
    if (rst) pc_q <= RESET_VECTOR;
    else pc_q <= pc_d;
  assign q = pc_q;
endmodule

// File: rtl/next_pc_mux.sv
// next_pc_mux: selects next PC (seq/branch/jump) and holds the PC register
// Optional misaligned-target flag enabled by NEXT_PC_MUX_ALIGN_CHECK_EN.
module next_pc_mux
  import next_pc_mux_pkg::*;
#(
  parameter int XLEN = next_pc_mux_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = next_pc_mux_pkg::RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] pc_plus_4,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic [1:0]      pc_src,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc,
  output logic            misalign_err
);
  always_comb begin
    next_pc = pc_plus_4;
    case (pc_src_e'(pc_src))
      PC_SRC_BRANCH: next_pc = branch_target;
      PC_SRC_JUMP:   next_pc = jump_target;
      default:       next_pc = pc_plus_4;
    endcase
  end
`ifdef NEXT_PC_MUX_ALIGN_CHECK_EN
  // only redirected targets are checked; pc_plus_4 is aligned by construction
  always_comb
    misalign_err = (pc_src_e'(pc_src) == PC_SRC_BRANCH || pc_src_e'(pc_src) == PC_SRC_JUMP)
                   && (next_pc[1:0] != 2'b00);
`else
  assign misalign_err = 1'b0;
`endif
  next_pc_mux_pc_reg #(.XLEN(XLEN), .RESET_VECTOR(RESET_VECTOR)) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .stall(stall),
    .d    (next_pc),
    .q    (pc)
  );
endmodule

// File: tb/tb_next_pc_mux.sv
// tb_next_pc_mux: scoreboard bench for next_pc_mux mux, PC register and align flag
module tb_next_pc_mux;
  logic        clk, rst, stall, misalign_err;
  logic [31:0] pc_plus_4, branch_target, jump_target, next_pc, pc;
  logic [1:0]  pc_src;
  typedef struct {string tag; int sig; logic [31:0] exp;} sb_t;
  sb_t sb[$];
  int chk_cnt = 0, pass_cnt = 0;
  logic [31:0] pc_m;
  next_pc_mux dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_plus_4(pc_plus_4),
    .branch_target(branch_target), .jump_target(jump_target), .pc_src(pc_src),
    .next_pc(next_pc), .pc(pc), .misalign_err(misalign_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] obs(input int sig);
    return sig == 0 ? next_pc : sig == 1 ? pc : {31'd0, misalign_err};
  endfunction
  function automatic logic [31:0] mdl_nxt();
    if (pc_src == 2'b01) return branch_target;
    if (pc_src == 2'b10) return jump_target;
    return pc_plus_4;
  endfunction
  function automatic logic [31:0] mdl_mis();
`ifdef NEXT_PC_MUX_ALIGN_CHECK_EN
    return {31'd0, (pc_src == 2'b01 || pc_src == 2'b10) && mdl_nxt() % 4 != 0};
`else
    return 32'd0;
`endif
  endfunction
  task automatic push(input string tag, input int sig, input logic [31:0] e);
    sb.push_back('{tag, sig, e});
  endtask
  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sig), e.exp);
    end
  endtask
  task automatic comb(input string tag, input logic [1:0] s, input logic [31:0] e);
    pc_src = s;
    push(tag, 0, e);
    #1 drain();
  endtask
  task automatic edge_chk(input string tag, input logic [31:0] e);
    push(tag, 1, e);
    @(posedge clk);
    #1 drain();
  endtask
  initial begin
    rst = 1'b0; stall = 1'b0; pc_src = 2'b00;
    pc_plus_4 = 32'd104; branch_target = 32'd200; jump_target = 32'd512;
    @(negedge clk);
    comb("seq", 2'b00, 32'd104);
    comb("branch", 2'b01, 32'd200);
    comb("jump", 2'b10, 32'd512);
    comb("rsvd", 2'b11, 32'd104);
    pc_src = 2'b10; rst = 1'b1;
    push("next_pc_in_rst", 0, 32'd512);
    edge_chk("pc_reset", 32'd0);
    rst = 1'b0;
    edge_chk("pc_load_jump", 32'd512);
    stall = 1'b1; pc_src = 2'b01;
    for (int i = 0; i < 3; i++) edge_chk($sformatf("pc_stall%0d", i), 32'd512);
    stall = 1'b0;
    edge_chk("pc_unstall", 32'd200);
    rst = 1'b1; stall = 1'b1;
    edge_chk("rst_over_stall", 32'd0);
    rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    branch_target = 32'd202; pc_plus_4 = 32'd106; jump_target = 32'd513;
`ifdef NEXT_PC_MUX_ALIGN_CHECK_EN
    push("mis_branch", 2, 32'd1);
    comb("mis_branch_pc", 2'b01, 32'd202);
    push("mis_seq", 2, 32'd0);
    comb("mis_seq_pc", 2'b00, 32'd106);
    push("mis_jump", 2, 32'd1);
    comb("mis_jump_pc", 2'b10, 32'd513);
`else
    push("nomis_jump", 2, 32'd0);
    comb("nomis_jump_pc", 2'b10, 32'd513);
    push("nomis_branch", 2, 32'd0);
    comb("nomis_branch_pc", 2'b01, 32'd202);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pc_m = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pc_plus_4 = $urandom; branch_target = $urandom; jump_target = $urandom;
      pc_src = 2'($urandom_range(0, 3));
      stall = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 15) == 0);
      #1;
      push("rnd_next_pc", 0, mdl_nxt());
      push("rnd_mis", 2, mdl_mis());
      drain();
      pc_m = rst ? 32'd0 : stall ? pc_m : mdl_nxt();
      edge_chk("rnd_pc", pc_m);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
